video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Raster timing source for the display path. Produces scan coordinates, blank and vsync
//  for FrameBufferReader, and latches renderer buffer-swap requests so flip changes only at
//  vertical blank. Emits panel-side hsync/vsync/de, delayed to line up with the reader's
//  registered out_color.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch (pixels)
//  H_SYNC      96   hsync width (pixels)
//  H_BP        48   horizontal back porch (pixels)
//  V_ACTIVE    480  visible lines
//  V_FP        10   vertical front porch (lines)
//  V_SYNC      2    vsync width (lines)
//  V_BP        33   vertical back porch (lines)
//  SYNC_POL    0    asserted level of hsync_out/vsync_out (0 = active-low)
//  SYNC_DELAY  1    pixel_en cycles of delay on hsync_out/vsync_out/de_out (>=1)
// PORTS
//  clk          in   1              system clock; single domain
//  resetn       in   1              asynchronous, active-low reset
//  pixel_en     in   1              pixel-rate strobe; state advances only when 1
//  swap_req     in   1              renderer finished a frame; request buffer flip
//  x            out  `SCREEN_COORD  horizontal count, 0..H_TOTAL-1
//  y            out  `SCREEN_COORD  vertical count, 0..V_TOTAL-1
//  blank        out  1              1 when x>=H_ACTIVE or y>=V_ACTIVE
//  vsync        out  1              1 while y in [V_ACTIVE+V_FP, +V_SYNC); undelayed, active-high
//  flip         out  1              selects the scan-out buffer (0 = FRAMEBUFFER_ADDR_0)
//  swap_ack     out  1              one-cycle pulse when a pending swap is applied
//  frame_count  out  16             visible frames started since reset; wraps
//  hsync_out    out  1              panel hsync, SYNC_POL, delayed SYNC_DELAY
//  vsync_out    out  1              panel vsync, SYNC_POL, delayed SYNC_DELAY
//  de_out       out  1              panel data enable = ~blank, delayed SYNC_DELAY
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//    `SCREEN_COORD must hold H_TOTAL-1.
//  - Reset: x=0, y=0, blank=0, vsync=0, flip=0, swap_ack=0, frame_count=0, pending=0.
//    Delay line is filled with inactive levels: hsync_out/vsync_out=~SYNC_POL, de_out=0.
//  - x, y, blank and vsync are registers updated together and are mutually consistent every cycle.
//    blank and vsync are decoded from next-state counts, so they add no latency.
//  - Counters advance on pixel_en=1:
//    x wraps H_TOTAL-1 -> 0 and then increments y; y wraps V_TOTAL-1 -> 0.
//    With pixel_en=0, all outputs hold, including the delay line.
//  - hsync (internal) is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  - Swap handling:
//    - swap_req=1 in any cycle sets pending (sticky). Further requests while pending are absorbed.
//    - At the vblank edge, when the counters step to (x=0, y=V_ACTIVE) under pixel_en:
//      if pending is 1, or swap_req is 1 in that same cycle, then flip toggles, swap_ack pulses
//      for 1 clk, and pending clears.
//    - A request in the cycle after the edge waits for the next frame.
//  - frame_count increments when (x, y) steps to (0, 0).
//  - Reset asserted mid-frame: everything returns to reset values at once. No partial sync pulse
//    is emitted after reset release; the delay line is clean.
//  - Delay line: SYNC_DELAY-deep shift register on {hsync, vsync, ~blank}, advanced by pixel_en,
//    with polarity applied at the output. Default 1 matches the reader's one-register colour output.
// STRUCTURE
//  - Types.sv: VIDEO_H_* / VIDEO_V_* timing defines and derived VIDEO_H_TOTAL / VIDEO_V_TOTAL.
//    These are the parameter defaults.
//  - Sub-module sync_delay_line #(WIDTH, DEPTH, RESET_VAL): enable-gated shift register, async
//    reset. Instantiated once, WIDTH=3.
//  - Top level: h/v counters, registered decode, swap FSM with states IDLE and PENDING.
//    IDLE -> PENDING on swap_req. PENDING -> IDLE at the vblank edge.
// TESTING
//  1. Reset, pixel_en=1 free-running:
//     hsync_out low for x 656..751 (delayed one cycle); 800 pixel_en cycles per line.
//     vsync high for y 490..491; frame length 420000 pixel_en cycles.
//  2. pixel_en=1 every 4th clk: same sequence, one step per strobe; outputs hold between strobes.
//  3. swap_req pulse at (x=100, y=200):
//     flip 0->1 and one swap_ack at the step to (0, 480); frame_count unchanged until (0, 0).
//  4. swap_req in the same cycle as the vblank edge -> applied this frame.
//     Request one cycle later -> applied next frame.
//     Two requests in one frame -> single toggle.
//  5. resetn low at (x=700, y=491), during sync:
//     all outputs take reset values immediately; hsync_out/vsync_out inactive until the next
//     natural sync window.
//  6. Alignment: for all x, y, de_out equals ~blank one pixel_en earlier; blank=1 exactly for
//     x>=640 or y>=480.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// video_timing_gen_pkg: raster timing defaults, coordinate type and swap FSM states
//   VIDEO_H_* / VIDEO_V_* : 640x480@60 timing, used as parameter defaults
//   COORD_W / coord_t     : scan coordinate width, must hold H_TOTAL-1
//   swap_state_t          : buffer-swap request FSM states
//   in_window()           : v in [lo, lo+len)
package video_timing_gen_pkg;

    localparam int VIDEO_H_ACTIVE = 640;
    localparam int VIDEO_H_FP     = 16;
    localparam int VIDEO_H_SYNC   = 96;
    localparam int VIDEO_H_BP     = 48;
    localparam int VIDEO_V_ACTIVE = 480;
    localparam int VIDEO_V_FP     = 10;
    localparam int VIDEO_V_SYNC   = 2;
    localparam int VIDEO_V_BP     = 33;
    localparam int VIDEO_H_TOTAL  = VIDEO_H_ACTIVE + VIDEO_H_FP + VIDEO_H_SYNC + VIDEO_H_BP;
    localparam int VIDEO_V_TOTAL  = VIDEO_V_ACTIVE + VIDEO_V_FP + VIDEO_V_SYNC + VIDEO_V_BP;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    function automatic logic in_window(coord_t v, int lo, int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// sync_delay_line: enable-gated DEPTH-stage shift register with async active-low reset
//   clk, resetn : clock, asynchronous active-low reset (stages load RESET_VAL)
//   en          : shift strobe; stages hold when 0
//   din / dout  : WIDTH-bit input / output after DEPTH enabled shifts
module sync_delay_line
    import video_timing_gen_pkg::*;
#(
    parameter int                WIDTH     = 1,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        else if (en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, blank/vsync decode, vblank-synchronised buffer flip, panel syncs
//   clk, resetn          : clock, asynchronous active-low reset
//   pixel_en             : pixel strobe; all state advances only when 1
//   swap_req             : renderer requests a buffer flip (latched until vblank)
//   x, y                 : scan coordinates
//   blank, vsync         : undelayed decode consistent with x, y
//   flip, swap_ack       : scan-out buffer select, one-clk pulse when a flip is applied
//   frame_count          : frames started since reset, wraps
//   hsync_out/vsync_out/de_out : panel signals, SYNC_POL polarity, SYNC_DELAY strobes late
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE   = VIDEO_H_ACTIVE,
    parameter int   H_FP       = VIDEO_H_FP,
    parameter int   H_SYNC     = VIDEO_H_SYNC,
    parameter int   H_BP       = VIDEO_H_BP,
    parameter int   V_ACTIVE   = VIDEO_V_ACTIVE,
    parameter int   V_FP       = VIDEO_V_FP,
    parameter int   V_SYNC     = VIDEO_V_SYNC,
    parameter int   V_BP       = VIDEO_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   SYNC_DELAY = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pixel_en,
    input  logic               swap_req,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               blank,
    output logic               vsync,
    output logic               flip,
    output logic               swap_ack,
    output logic [15:0]        frame_count,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    swap_state_t        state;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               x_wrap, vblank_edge, frame_edge, hsync;
    logic [2:0]         dly;

    assign x_wrap      = int'(x) == H_TOTAL - 1;
    assign x_nxt       = x_wrap ? '0 : x + 1'b1;
    assign y_nxt       = !x_wrap ? y : (int'(y) == V_TOTAL - 1 ? '0 : y + 1'b1);
    // x_nxt is 0 exactly when x wraps, so only y_nxt needs testing
    assign vblank_edge = pixel_en && x_wrap && int'(y_nxt) == V_ACTIVE;
    assign frame_edge  = pixel_en && x_wrap && y_nxt == '0;
    assign hsync       = in_window(x, H_ACTIVE + H_FP, H_SYNC);

    // blank/vsync are decoded from the next counts so they line up with x/y
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            x           <= '0;
            y           <= '0;
            blank       <= 1'b0;
            vsync       <= 1'b0;
            frame_count <= '0;
        end else if (pixel_en) begin
            x           <= x_nxt;
            y           <= y_nxt;
            blank       <= int'(x_nxt) >= H_ACTIVE || int'(y_nxt) >= V_ACTIVE;
            vsync       <= in_window(y_nxt, V_ACTIVE + V_FP, V_SYNC);
            frame_count <= frame_edge ? frame_count + 16'd1 : frame_count;
        end

    // A request arriving in the edge cycle itself is honoured without passing through PENDING
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state    <= IDLE;
            flip     <= 1'b0;
            swap_ack <= 1'b0;
        end else if (vblank_edge && (state == PENDING || swap_req)) begin
            state    <= IDLE;
            flip     <= ~flip;
            swap_ack <= 1'b1;
        end else begin
            swap_ack <= 1'b0;
            if (swap_req) state <= PENDING;
        end

    // Delay line carries active-high levels; reset to all-inactive so no stale pulse escapes
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (3'b000)
    ) u_sync_delay_line (
        .clk    (clk),
        .resetn (resetn),
        .en     (pixel_en),
        .din    ({hsync, vsync, ~blank}),
        .dout   (dly)
    );

    assign hsync_out = SYNC_POL ? dly[2] : ~dly[2];
    assign vsync_out = SYNC_POL ? dly[1] : ~dly[1];
    assign de_out    = dly[0];

endmodule
